// File: rtl/lpf_pkg.sv
// Shared types and defaults for the lpf filter and its coefficient loader.
// Both sides take the coefficient width from here so they always agree.
package lpf_pkg;

  localparam int COEFFICIENT_LEN = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    COMMIT
  } coeff_ld_state_t;

endpackage

// File: rtl/lpf_coeff_loader.sv
// Serial coefficient loader: fills a shadow bank beat by beat and commits
// it atomically to coeff_o only when the frame has exactly TAP_NUM beats.
module lpf_coeff_loader #(
  parameter int TAP_NUM         = 16,
  parameter int COEFFICIENT_LEN = lpf_pkg::COEFFICIENT_LEN
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic [COEFFICIENT_LEN-1:0]              s_data,
  input  logic                                    s_last,
  output logic [TAP_NUM-1:0][COEFFICIENT_LEN-1:0] coeff_o,
  output logic                                    coeff_update_o,
  output logic                                    busy_o,
  output logic                                    err_o
);

  import lpf_pkg::*;

  localparam int IDX_W = $clog2(TAP_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAP_NUM - 1);

  coeff_ld_state_t state_q;
  logic [IDX_W-1:0] idx_q;
  logic [TAP_NUM-1:0][COEFFICIENT_LEN-1:0] shadow_q;
  logic [TAP_NUM-1:0][COEFFICIENT_LEN-1:0] coeff_q;
  logic rdy_q;
  logic upd_q;
  logic err_q;
  logic take;

  assign take           = s_valid && rdy_q;
  assign s_ready        = rdy_q;
  assign coeff_o        = coeff_q;
  assign coeff_update_o = upd_q;
  assign err_o          = err_q;
  assign busy_o         = (state_q != IDLE);

  // Frame FSM: shadow fill, size checks, atomic commit, registered flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      coeff_q  <= '0;
      rdy_q    <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          idx_q <= '0;
          if (take) begin
            if (s_last) begin
              err_q <= 1'b1;
            end else begin
              shadow_q[0] <= s_data;
              idx_q       <= IDX_W'(1);
              state_q     <= LOAD;
            end
          end
        end
        LOAD: begin
          if (take) begin
            shadow_q[idx_q] <= s_data;
            if (idx_q == LAST_IDX) begin
              if (s_last) begin
                state_q <= COMMIT;
                rdy_q   <= 1'b0;
              end else begin
                err_q   <= 1'b1;
                state_q <= DRAIN;
              end
            end else if (s_last) begin
              err_q   <= 1'b1;
              idx_q   <= '0;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (take && s_last) begin
            idx_q   <= '0;
            state_q <= IDLE;
          end
        end
        COMMIT: begin
          coeff_q <= shadow_q;
          upd_q   <= 1'b1;
          rdy_q   <= 1'b1;
          idx_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpf_coeff_loader.sv
// Randomized bench for lpf_coeff_loader with a frame-level reference model
// compared every cycle, plus hand-computed expectations for directed cases.
module tb_lpf_coeff_loader;

  localparam int TN = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic [CW-1:0] s_data = '0;
  logic s_ready;
  logic coeff_update_o;
  logic busy_o;
  logic err_o;
  logic [TN-1:0][CW-1:0] coeff_o;

  always #5 clk = ~clk;

  lpf_coeff_loader #(
    .TAP_NUM(TN),
    .COEFFICIENT_LEN(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .coeff_o(coeff_o),
    .coeff_update_o(coeff_update_o),
    .busy_o(busy_o),
    .err_o(err_o)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [TN*CW-1:0] act,
                     input logic [TN*CW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
  endtask

  // Reference model: counts beats per frame and applies the size rules.
  logic [TN-1:0][CW-1:0] m_coeff = '0;
  logic [TN-1:0][CW-1:0] m_bank = '0;
  bit m_ready = 0, m_upd = 0, m_err = 0, m_commit = 0, started = 0;
  int m_len = 0;

  always @(posedge clk) begin
    bit take;
    int pos;
    started = 1;
    if (!rst_n) begin
      m_coeff = '0; m_bank = '0; m_ready = 0;
      m_upd = 0; m_err = 0; m_commit = 0; m_len = 0;
    end else begin
      take = s_valid && m_ready;
      m_upd = 0;
      m_err = 0;
      if (m_commit) begin
        m_coeff = m_bank; m_upd = 1; m_commit = 0; m_ready = 1;
      end else begin
        m_ready = 1;
        if (take) begin
          pos = m_len;
          if (pos < TN) m_bank[pos] = s_data;
          if (s_last) begin
            if (pos < TN - 1) m_err = 1;
            else if (pos == TN - 1) begin m_commit = 1; m_ready = 0; end
            m_len = 0;
          end else begin
            if (pos == TN - 1) m_err = 1;
            m_len = pos + 1;
          end
        end
      end
    end
  end

  int err_seen = 0, upd_seen = 0, stall_seen = 0, busy_seen = 0;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("s_ready", TN*CW'(s_ready), TN*CW'(m_ready));
      chk("busy", TN*CW'(busy_o), TN*CW'((m_len > 0) || m_commit));
      chk("err", TN*CW'(err_o), TN*CW'(m_err));
      chk("update", TN*CW'(coeff_update_o), TN*CW'(m_upd));
      chk("coeff", coeff_o, m_coeff);
      if (err_o) err_seen++;
      if (coeff_update_o) upd_seen++;
      if (s_valid && !s_ready && rst_n) stall_seen++;
      if (busy_o) busy_seen++;
    end
  end

  logic [CW-1:0] frame_d [32];

  task automatic wait_accept();
    int t = 0;
    do begin @(negedge clk); t++; end while (!s_ready && t < 50);
    if (!s_ready) begin
      checks++;
      $display("FAIL accept_timeout act=0 exp=1 t=%0t", $time);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int n, input bit do_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data = frame_d[i];
      s_last = do_last && (i == n - 1);
      wait_accept();
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        s_last = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle(input int k);
    s_valid = 1'b0;
    s_last = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 32; i++) frame_d[i] = CW'($urandom);
  endtask

  int e0, u0, s0, b0, len;
  int lens [6] = '{1, 5, 15, 16, 17, 20};

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", TN*CW'(s_ready), '0);
    chk("rst_coeff", coeff_o, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // ascending taps with gaps
    for (int i = 0; i < TN; i++) frame_d[i] = CW'(i + 1);
    e0 = err_seen; u0 = upd_seen;
    send_frame(TN, 1'b1, 1'b1);
    idle(4);
    chk("t1_tap0", TN*CW'(coeff_o[0]), TN*CW'(1));
    chk("t1_tap7", TN*CW'(coeff_o[7]), TN*CW'(8));
    chk("t1_tap15", TN*CW'(coeff_o[15]), TN*CW'(16));
    chk("t1_upd", TN*CW'(upd_seen - u0), TN*CW'(1));
    chk("t1_err", TN*CW'(err_seen - e0), '0);

    // bank A then a short frame
    for (int i = 0; i < TN; i++) frame_d[i] = 16'h7FFF;
    send_frame(TN, 1'b1, 1'b0);
    idle(3);
    for (int i = 0; i < 5; i++) frame_d[i] = CW'(16'h1234 + i);
    e0 = err_seen;
    send_frame(5, 1'b1, 1'b0);
    idle(3);
    chk("t2_err", TN*CW'(err_seen - e0), TN*CW'(1));
    chk("t2_tap4", TN*CW'(coeff_o[4]), TN*CW'(16'h7FFF));
    chk("t2_tap0", TN*CW'(coeff_o[0]), TN*CW'(16'h7FFF));
    rand_frame();
    frame_d[3] = 16'h8001;
    send_frame(TN, 1'b1, 1'b1);
    idle(4);
    chk("t2_b_tap3", TN*CW'(coeff_o[3]), TN*CW'(16'h8001));

    // long frame of 20 beats
    for (int i = 0; i < 20; i++) frame_d[i] = CW'(16'h5500 + i);
    e0 = err_seen; u0 = upd_seen;
    send_frame(20, 1'b1, 1'b0);
    idle(3);
    chk("t3_err", TN*CW'(err_seen - e0), TN*CW'(1));
    chk("t3_upd", TN*CW'(upd_seen - u0), '0);
    chk("t3_keep", TN*CW'(coeff_o[3]), TN*CW'(16'h8001));
    chk("t3_idle", TN*CW'(busy_o), '0);

    // single-beat frame
    frame_d[0] = 16'h0042;
    e0 = err_seen; b0 = busy_seen;
    send_frame(1, 1'b1, 1'b0);
    idle(3);
    chk("t4_err", TN*CW'(err_seen - e0), TN*CW'(1));
    chk("t4_busy", TN*CW'(busy_seen - b0), '0);

    // two back-to-back frames with s_valid held
    u0 = upd_seen; s0 = stall_seen;
    for (int i = 0; i < TN; i++) frame_d[i] = CW'(16'hA000 + i);
    send_frame(TN, 1'b1, 1'b0);
    for (int i = 0; i < TN; i++) frame_d[i] = CW'(16'hB000 + i);
    send_frame(TN, 1'b1, 1'b0);
    idle(4);
    chk("t5_stall", TN*CW'(stall_seen - s0), TN*CW'(1));
    chk("t5_upd", TN*CW'(upd_seen - u0), TN*CW'(2));
    chk("t5_tap9", TN*CW'(coeff_o[9]), TN*CW'(16'hB009));

    // reset after beat 8
    rand_frame();
    send_frame(8, 1'b0, 1'b0);
    s_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_coeff", coeff_o, '0);
    chk("t6_busy", TN*CW'(busy_o), '0);
    @(posedge clk); #1;
    for (int i = 0; i < TN; i++) frame_d[i] = CW'(16'hC0DE ^ i);
    send_frame(TN, 1'b1, 1'b1);
    idle(4);
    chk("t6_tap5", TN*CW'(coeff_o[5]), TN*CW'(16'hC0DE ^ 5));

    // randomized frames of mixed sizes
    for (int f = 0; f < 40; f++) begin
      rand_frame();
      len = lens[$urandom_range(0, 5)];
      send_frame(len, 1'b1, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end
    idle(6);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lpf_coeff_loader.md
# lpf_coeff_loader

Writer side of the `lpf` coefficient bus. It accepts a serial stream of FIR coefficients over a valid/ready handshake into a shadow bank. When a frame is complete and correctly sized, it commits the whole bank atomically onto the parallel `coeff_o` bus that drives the filter's `coeff_i`. Malformed frames are discarded and flagged, and the active bank is never partially updated.

## Interface
- `TAP_NUM`, 16: number of taps; must be ≥ 2.
- `COEFFICIENT_LEN`, 16: coefficient width in bits, two's complement.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: synchronous, active-low.
- `s_valid`  in  1  coefficient beat valid.
- `s_ready`  out  1  loader can accept a beat.
- `s_data`  in  COEFFICIENT_LEN  signed coefficient.
- `s_last`  in  1  final beat of frame.
- `coeff_o`  out  TAP_NUM×COEFFICIENT_LEN  packed active bank; `coeff_o[i]` is tap i; connects to `lpf.coeff_i`.
- `coeff_update_o`  out  1  one-cycle pulse; high in the first cycle a new bank is visible on `coeff_o`.
- `busy_o`  out  1  high while a frame is in progress (state ≠ IDLE).
- `err_o`  out  1  one-cycle pulse; the previous frame was malformed.

## Operation
- A beat transfers when `s_valid && s_ready`. Nothing else changes state.
- Frame ordering: the first beat is tap 0, which multiplies the newest sample. Beat k is tap k.
- FSM states and transitions:
  - **IDLE**: `s_ready`=1, idx=0.
    - Beat with `s_last`=0: write shadow[0], set idx=1, go to LOAD.
    - Beat with `s_last`=1: short frame. Pulse `err_o`, stay in IDLE, leave shadow unchanged.
  - **LOAD**: `s_ready`=1. Each beat writes shadow[idx].
    - idx<TAP_NUM−1, `s_last`=0: increment idx.
    - idx<TAP_NUM−1, `s_last`=1: short frame. Pulse `err_o`, go to IDLE.
    - idx=TAP_NUM−1, `s_last`=1: go to COMMIT.
    - idx=TAP_NUM−1, `s_last`=0: long frame. Pulse `err_o`, go to DRAIN.
  - **DRAIN**: `s_ready`=1. Discard beats. A beat with `s_last`=1 returns the FSM to IDLE with no further `err_o`.
  - **COMMIT**: `s_ready`=0. Copy the full shadow bank to `coeff_o` in one cycle, then go to IDLE.
- `coeff_o` changes only on COMMIT or reset. Short and long frames leave it untouched.
- idx counter width is `$clog2(TAP_NUM)`. It never wraps: the long-frame check happens before any increment past TAP_NUM−1.
- Reset values:
  - `coeff_o`=0 (filter output is zero until the first load).
  - `coeff_update_o`=0, `err_o`=0, `busy_o`=0, `s_ready`=0.
  - State is IDLE. Shadow bank is 0.
  - `s_ready` is driven from the registered state; it goes to 1 in the first cycle after `rst_n` deasserts.
- Reset mid-frame discards all partial shadow content and also clears the active bank.

## Timing
- Last beat accepted in cycle N: COMMIT occupies N+1. `coeff_o` takes the new value and `coeff_update_o`=1 in N+2.
- The earliest first beat of the next frame is N+2, because `s_ready` is 0 in N+1.
- Minimum frame-to-frame period is TAP_NUM+1 cycles.
- `err_o` is high in the cycle after the offending beat; it is registered.
- Flow control: `s_valid` may be held with `s_ready` low; the beat is taken on the first cycle `s_ready` is high. Gaps in `s_valid` are allowed at any point.
- All outputs are registered. There is no combinational path from `s_*` inputs to any output.

## Structure
- Package `lpf_pkg`:
  - `typedef enum logic [1:0] {IDLE, LOAD, DRAIN, COMMIT} coeff_ld_state_t`.
  - Shared `COEFFICIENT_LEN` default, so `lpf` and the loader agree on it.
- Single module, no sub-module. The shadow bank is a parameterised register array.

## Test plan
- Load coefficients 1..16 with gaps in `s_valid` → `coeff_o[i]`=i+1 in N+2; single `coeff_update_o` pulse; `err_o` never asserts.
- Load bank A = all 0x7FFF, then short frame of 5 beats with `s_last` on the 5th → `err_o` pulse in the next cycle; `coeff_o` stays 0x7FFF; a following valid frame B commits normally.
- Long frame of 20 beats, `s_last` on beat 20 → `err_o` pulses once after beat 16; beats 17–20 accepted and discarded; `coeff_o` unchanged; FSM back in IDLE.
- Single-beat frame (`s_last` on the first beat) → `err_o` pulse; `busy_o` stays 0.
- `s_valid` held high back-to-back across two full frames → `s_ready` low for exactly one cycle between frames; both banks commit, each with its own `coeff_update_o` pulse.
- `rst_n` low for 1 cycle after beat 8 of a frame → `coeff_o`=0 and `busy_o`=0; a fresh 16-beat frame then commits correctly.
